// File: rtl/hbuf_pg_ring_if.sv
// Control/status bundle for the DDR3 page ring. The master drives configuration,
// write-advance and page-free requests; the slave (the ring) returns pointers and flags.
interface hbuf_pg_ring_if #(
    parameter int PG_W  = 16,
    parameter int OVF_W = 16
);
    logic              en;
    logic [PG_W-1:0]   start_pg;
    logic [PG_W-1:0]   stop_pg;
    logic [PG_W-1:0]   first_pg;
    logic [PG_W-1:0]   last_pg;
    logic              cfg_err;
    logic              wr_adv;
    logic              wr_drop;
    logic              pg_clr_req;
    logic              pg_clr_ack;
    logic [PG_W-1:0]   pg_clr_cnt;
    logic [PG_W-1:0]   rd_pg_num;
    logic [PG_W-1:0]   wr_pg_num;
    logic [PG_W:0]     n_used_pgs;
    logic              empty;
    logic              full;
    logic              afull;
    logic [PG_W:0]     afull_thresh;
    logic [OVF_W-1:0]  ovf_cnt;
    logic              ovf_clr;

    modport master (
        output en, start_pg, stop_pg, wr_adv, pg_clr_req, pg_clr_cnt, afull_thresh, ovf_clr,
        input  first_pg, last_pg, cfg_err, wr_drop, pg_clr_ack, rd_pg_num, wr_pg_num,
               n_used_pgs, empty, full, afull, ovf_cnt
    );

    modport slave (
        input  en, start_pg, stop_pg, wr_adv, pg_clr_req, pg_clr_cnt, afull_thresh, ovf_clr,
        output first_pg, last_pg, cfg_err, wr_drop, pg_clr_ack, rd_pg_num, wr_pg_num,
               n_used_pgs, empty, full, afull, ovf_cnt
    );
endinterface

// File: rtl/hbuf_pg_ring.sv
// Page-granular ring pointer manager for a DDR3 history buffer: write pointer advances
// one page per shipped page, read pointer jumps forward by a clipped free count.
module hbuf_pg_ring #(
    parameter int PG_W  = 16,
    parameter int OVF_W = 16
) (
    input  logic          clk,
    input  logic          rst,
    hbuf_pg_ring_if.slave bus
);
    localparam int AW = PG_W + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_ERR} state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic              r_en_q;
    logic              r_arm;
    logic              r_req_q;
    logic [PG_W-1:0]   r_first;
    logic [PG_W-1:0]   r_last;
    logic [PG_W-1:0]   r_rd;
    logic [PG_W-1:0]   r_wr;
    logic [AW-1:0]     r_n_alloc;
    logic [AW-1:0]     r_n_used;
    logic              r_cfg_err;
    logic              r_ack;
    logic              r_drop;
    logic [OVF_W-1:0]  r_ovf;

    logic              w_rise;
    logic              w_cfg_bad;
    logic              w_run;
    logic              w_full;
    logic              w_acc;
    logic              w_drop;
    logic              w_clr_go;
    logic [AW-1:0]     w_clip;
    logic [AW-1:0]     w_rd_sum;
    logic [PG_W-1:0]   w_wr_nxt;

    // r_arm keeps an en level held across reset from looking like a fresh rising edge
    assign w_rise    = bus.en & ~r_en_q & r_arm;
    assign w_cfg_bad = bus.stop_pg < bus.start_pg;
    assign w_run     = (r_state == ST_RUN) & bus.en;
    assign w_full    = (r_n_used == r_n_alloc) & r_en_q;
    assign w_acc     = w_run & bus.wr_adv & ~w_full;
    assign w_drop    = w_run & bus.wr_adv & w_full;
    assign w_clr_go  = w_run & bus.pg_clr_req & ~r_req_q & ~r_ack;
    assign w_rd_sum  = {1'b0, r_rd} + w_clip;
    assign w_wr_nxt  = (r_wr == r_last) ? r_first : r_wr + PG_W'(1);

    always_comb begin
        w_clip = '0;
        if (w_clr_go)
            w_clip = ({1'b0, bus.pg_clr_cnt} < r_n_used) ? {1'b0, bus.pg_clr_cnt} : r_n_used;
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (!bus.en)
            w_state_nxt = ST_IDLE;
        else if (w_rise)
            w_state_nxt = w_cfg_bad ? ST_ERR : ST_RUN;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_en_q    <= 1'b0;
            r_arm     <= 1'b0;
            r_req_q   <= 1'b0;
            r_first   <= '0;
            r_last    <= '0;
            r_rd      <= '0;
            r_wr      <= '0;
            r_n_alloc <= '0;
            r_n_used  <= '0;
            r_cfg_err <= 1'b0;
            r_ack     <= 1'b0;
            r_drop    <= 1'b0;
            r_ovf     <= '0;
        end else begin
            r_en_q  <= bus.en;
            r_req_q <= bus.pg_clr_req;
            r_drop  <= w_drop;

            // a clear in the same cycle as a counted drop leaves that drop on the count
            if (bus.ovf_clr)
                r_ovf <= w_drop ? OVF_W'(1) : '0;
            else if (w_drop && (r_ovf != '1))
                r_ovf <= r_ovf + OVF_W'(1);

            if (!bus.en) begin
                r_arm     <= 1'b1;
                r_first   <= '0;
                r_last    <= '0;
                r_rd      <= '0;
                r_wr      <= '0;
                r_n_alloc <= '0;
                r_n_used  <= '0;
                r_cfg_err <= 1'b0;
                r_ack     <= bus.pg_clr_req;
            end else if (w_rise) begin
                r_first   <= bus.start_pg;
                r_last    <= bus.stop_pg;
                r_rd      <= bus.start_pg;
                r_wr      <= bus.start_pg;
                r_n_alloc <= {1'b0, bus.stop_pg} - {1'b0, bus.start_pg} + AW'(1);
                r_n_used  <= '0;
                r_cfg_err <= w_cfg_bad;
                r_ack     <= 1'b0;
            end else if (w_run) begin
                if (w_clr_go) begin
                    // rd + clip never exceeds last + n_alloc, so one subtraction wraps it
                    r_rd  <= PG_W'((w_rd_sum > {1'b0, r_last}) ? (w_rd_sum - r_n_alloc) : w_rd_sum);
                    r_ack <= 1'b1;
                end else if (!bus.pg_clr_req) begin
                    r_ack <= 1'b0;
                end
                if (w_acc)
                    r_wr <= w_wr_nxt;
                r_n_used <= r_n_used + AW'(w_acc) - w_clip;
            end
        end
    end

    assign bus.first_pg   = r_first;
    assign bus.last_pg    = r_last;
    assign bus.cfg_err    = r_cfg_err;
    assign bus.wr_drop    = r_drop;
    assign bus.pg_clr_ack = r_ack;
    assign bus.rd_pg_num  = r_rd;
    assign bus.wr_pg_num  = r_wr;
    assign bus.n_used_pgs = r_n_used;
    assign bus.ovf_cnt    = r_ovf;
    assign bus.empty      = (r_n_used == '0);
    assign bus.full       = w_full;
    assign bus.afull      = (r_n_used >= bus.afull_thresh) & r_en_q;
endmodule
